// File: rtl/color_apply_engine.sv
// Queued color-property resolver: resolves ident/rgb requests into
// registered regular and visited style colors, with an external keyword LUT.
module color_apply_engine #(
    parameter int NUM_PROPS  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int COLOR_W    = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [$clog2(NUM_PROPS)-1:0]   req_prop,
    input  logic                           req_is_ident,
    input  logic                           req_is_rgb,
    input  logic [9:0]                     req_ident,
    input  logic [COLOR_W-1:0]             req_rgb,
    input  logic                           req_apply_regular,
    input  logic                           req_apply_visited,
    input  logic                           req_inherit_current,
    input  logic [NUM_PROPS*COLOR_W-1:0]   parent_color,
    input  logic [NUM_PROPS-1:0]           parent_valid,
    input  logic                           is_link_element,
    input  logic [COLOR_W-1:0]             doc_text,
    input  logic [COLOR_W-1:0]             doc_link,
    input  logic [COLOR_W-1:0]             doc_visited_link,
    input  logic [COLOR_W-1:0]             doc_active_link,
    input  logic [9:0]                     id_currentcolor,
    input  logic [9:0]                     id_webkit_text,
    input  logic [9:0]                     id_webkit_link,
    input  logic [9:0]                     id_webkit_activelink,
    output logic                           lut_req_valid,
    output logic [9:0]                     lut_ident,
    input  logic                           lut_resp_valid,
    input  logic [COLOR_W-1:0]             lut_color,
    output logic [NUM_PROPS*COLOR_W-1:0]   color_out,
    output logic [NUM_PROPS*COLOR_W-1:0]   visited_color_out,
    output logic                           busy
);

    localparam int PW = $clog2(NUM_PROPS);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [PW-1:0]      prop;
        logic               isIdent;
        logic               isRgb;
        logic [9:0]         ident;
        logic [COLOR_W-1:0] rgb;
        logic               applyReg;
        logic               applyVis;
        logic               inherit;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        RESOLVE,
        LUT_WAIT
    } state_t;

    state_t state;
    state_t stateNext;

    req_t   fifoMem [FIFO_DEPTH];
    req_t   reqIn;
    req_t   work;

    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   count;
    logic          full;
    logic          pushEn;
    logic          popEn;

    logic [NUM_PROPS-1:0][COLOR_W-1:0] colorQ;
    logic [NUM_PROPS-1:0][COLOR_W-1:0] visQ;
    logic [NUM_PROPS-1:0][COLOR_W-1:0] parentArr;

    logic               lutReqQ;
    logic [9:0]         lutIdentQ;
    logic               isCur;
    logic               doWrite;
    logic               needLut;
    logic [COLOR_W-1:0] regVal;
    logic [COLOR_W-1:0] visVal;
    logic               wrEn;
    logic [COLOR_W-1:0] wrReg;
    logic [COLOR_W-1:0] wrVis;

    assign reqIn = '{
        prop:     req_prop,
        isIdent:  req_is_ident,
        isRgb:    req_is_rgb,
        ident:    req_ident,
        rgb:      req_rgb,
        applyReg: req_apply_regular,
        applyVis: req_apply_visited,
        inherit:  req_inherit_current
    };

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign req_ready = !full;
    assign pushEn    = req_valid && !full;
    assign popEn     = (state == IDLE) && (count != '0);
    assign busy      = (count != '0) || (state != IDLE);

    assign parentArr         = parent_color;
    assign color_out         = colorQ;
    assign visited_color_out = visQ;
    assign lut_req_valid     = lutReqQ;
    assign lut_ident         = lutIdentQ;

    assign isCur = work.isIdent && (work.ident == id_currentcolor);

    // Priority resolution of the working request into regular/visited values
    always_comb begin
        regVal  = '0;
        visVal  = '0;
        doWrite = 1'b0;
        needLut = 1'b0;
        if (isCur && work.inherit) begin
            doWrite = 1'b1;
            regVal  = parent_valid[work.prop] ? parentArr[work.prop] : '0;
            visVal  = regVal;
        end else if (isCur) begin
            doWrite = 1'b1;
            regVal  = colorQ[0];
            visVal  = visQ[0];
        end else if (work.isIdent && work.ident == id_webkit_text) begin
            doWrite = 1'b1;
            regVal  = doc_text;
            visVal  = doc_text;
        end else if (work.isIdent && work.ident == id_webkit_link) begin
            doWrite = 1'b1;
            regVal  = doc_link;
            visVal  = is_link_element ? doc_visited_link : doc_link;
        end else if (work.isIdent && work.ident == id_webkit_activelink) begin
            doWrite = 1'b1;
            regVal  = doc_active_link;
            visVal  = doc_active_link;
        end else if (work.isIdent) begin
            needLut = 1'b1;
        end else if (work.isRgb) begin
            doWrite = 1'b1;
            regVal  = work.rgb;
            visVal  = work.rgb;
        end
    end

    always_comb begin
        stateNext = state;
        wrEn      = 1'b0;
        wrReg     = regVal;
        wrVis     = visVal;
        unique case (state)
            IDLE: begin
                if (count != '0) stateNext = RESOLVE;
            end
            RESOLVE: begin
                wrEn      = doWrite;
                stateNext = needLut ? LUT_WAIT : IDLE;
            end
            LUT_WAIT: begin
                wrReg = lut_color;
                wrVis = lut_color;
                if (lut_resp_valid) begin
                    wrEn      = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (pushEn) fifoMem[wrPtr] <= reqIn;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            work  <= '0;
        end else begin
            if (pushEn) wrPtr <= wrPtr + 1'b1;
            if (popEn) begin
                rdPtr <= rdPtr + 1'b1;
                work  <= fifoMem[rdPtr];
            end
            if (pushEn && !popEn)      count <= count + 1'b1;
            else if (popEn && !pushEn) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lutReqQ   <= 1'b0;
            lutIdentQ <= '0;
        end else if (state == RESOLVE && needLut) begin
            lutReqQ   <= 1'b1;
            lutIdentQ <= work.ident;
        end else if (state == LUT_WAIT && lut_resp_valid) begin
            lutReqQ   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            colorQ <= '0;
            visQ   <= '0;
        end else if (wrEn) begin
            if (work.applyReg) colorQ[work.prop] <= wrReg;
            if (work.applyVis) visQ[work.prop]   <= wrVis;
        end
    end

endmodule

// File: tb/tb_color_apply_engine.sv
// Directed bench for color_apply_engine: hand-computed vectors checked
// with immediate assertions after each step.
module tb_color_apply_engine;

    localparam int NP = 4;
    localparam int FD = 4;
    localparam int CW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_prop;
    logic            req_is_ident;
    logic            req_is_rgb;
    logic [9:0]      req_ident;
    logic [CW-1:0]   req_rgb;
    logic            req_apply_regular;
    logic            req_apply_visited;
    logic            req_inherit_current;
    logic [NP*CW-1:0] parent_color;
    logic [NP-1:0]   parent_valid;
    logic            is_link_element;
    logic [CW-1:0]   doc_text;
    logic [CW-1:0]   doc_link;
    logic [CW-1:0]   doc_visited_link;
    logic [CW-1:0]   doc_active_link;
    logic [9:0]      id_currentcolor;
    logic [9:0]      id_webkit_text;
    logic [9:0]      id_webkit_link;
    logic [9:0]      id_webkit_activelink;
    logic            lut_req_valid;
    logic [9:0]      lut_ident;
    logic            lut_resp_valid;
    logic [CW-1:0]   lut_color;
    logic [NP*CW-1:0] color_out;
    logic [NP*CW-1:0] visited_color_out;
    logic            busy;

    int nAsserts = 0;
    int nFail    = 0;
    int accepted = 0;

    always #5 clk = ~clk;

    color_apply_engine #(
        .NUM_PROPS (NP),
        .FIFO_DEPTH(FD),
        .COLOR_W   (CW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_prop            (req_prop),
        .req_is_ident        (req_is_ident),
        .req_is_rgb          (req_is_rgb),
        .req_ident           (req_ident),
        .req_rgb             (req_rgb),
        .req_apply_regular   (req_apply_regular),
        .req_apply_visited   (req_apply_visited),
        .req_inherit_current (req_inherit_current),
        .parent_color        (parent_color),
        .parent_valid        (parent_valid),
        .is_link_element     (is_link_element),
        .doc_text            (doc_text),
        .doc_link            (doc_link),
        .doc_visited_link    (doc_visited_link),
        .doc_active_link     (doc_active_link),
        .id_currentcolor     (id_currentcolor),
        .id_webkit_text      (id_webkit_text),
        .id_webkit_link      (id_webkit_link),
        .id_webkit_activelink(id_webkit_activelink),
        .lut_req_valid       (lut_req_valid),
        .lut_ident           (lut_ident),
        .lut_resp_valid      (lut_resp_valid),
        .lut_color           (lut_color),
        .color_out           (color_out),
        .visited_color_out   (visited_color_out),
        .busy                (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic acc;
        acc = req_valid && req_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            req_valid = 1'b0;
            accepted++;
        end
    endtask

    task automatic push(input logic [1:0] p, input logic isI,
                        input logic isR, input logic [9:0] id,
                        input logic [31:0] rgb, input logic ar,
                        input logic av, input logic inh);
        req_prop            = p;
        req_is_ident        = isI;
        req_is_rgb          = isR;
        req_ident           = id;
        req_rgb             = rgb;
        req_apply_regular   = ar;
        req_apply_visited   = av;
        req_inherit_current = inh;
        req_valid           = 1'b1;
        step();
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        chk(tag, 128'(busy), 128'(1'b0));
    endtask

    task automatic waitLut(input string tag);
        int n = 0;
        while (!lut_req_valid && n < 50) begin
            step();
            n++;
        end
        chk(tag, 128'(lut_req_valid), 128'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req_valid = 0; req_prop = 0; req_is_ident = 0; req_is_rgb = 0;
        req_ident = 0; req_rgb = 0; req_apply_regular = 0;
        req_apply_visited = 0; req_inherit_current = 0;
        parent_color = '0; parent_valid = '0; is_link_element = 0;
        doc_text = 0; doc_link = 0; doc_visited_link = 0; doc_active_link = 0;
        id_currentcolor = 10'd100; id_webkit_text = 10'd101;
        id_webkit_link = 10'd102; id_webkit_activelink = 10'd103;
        lut_resp_valid = 0; lut_color = 0;

        #12;
        chk("rst_color", color_out, 128'h0);
        chk("rst_vis", visited_color_out, 128'h0);
        chk("rst_lutreq", 128'(lut_req_valid), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        step(); step();
        reset = 1'b1;
        step();
        chk("rel_ready", 128'(req_ready), 128'(1'b1));

        push(2'd2, 0, 1, 10'd0, 32'hFF0000FF, 1, 1, 0);
        step();
        chk("rgb_t1", color_out, 128'h0);
        step();
        chk("rgb_reg", color_out,
            128'h00000000_FF0000FF_00000000_00000000);
        chk("rgb_vis", visited_color_out,
            128'h00000000_FF0000FF_00000000_00000000);
        chk("rgb_busy", 128'(busy), 128'(1'b0));

        push(2'd1, 0, 1, 10'd0, 32'h55555555, 1, 1, 0);
        waitIdle("idle_pre_inh");
        parent_color = {32'h0, 32'h0, 32'h11223344, 32'hDEADDEAD};
        parent_valid = 4'b1101;
        push(2'd1, 1, 0, 10'd100, 32'h0, 1, 1, 1);
        waitIdle("idle_inh0");
        chk("inh_invalid", color_out,
            128'h00000000_FF0000FF_00000000_00000000);
        parent_valid = 4'b0010;
        push(2'd1, 1, 0, 10'd100, 32'h0, 1, 1, 1);
        waitIdle("idle_inh1");
        chk("inh_valid_reg", color_out,
            128'h00000000_FF0000FF_11223344_00000000);
        chk("inh_valid_vis", visited_color_out,
            128'h00000000_FF0000FF_11223344_00000000);

        push(2'd0, 0, 1, 10'd0, 32'h0C0C0C0C, 1, 0, 0);
        push(2'd0, 0, 1, 10'd0, 32'h0D0D0D0D, 0, 1, 0);
        push(2'd3, 1, 0, 10'd100, 32'h0, 1, 1, 0);
        waitIdle("idle_cur");
        chk("cur_reg", color_out,
            128'h0C0C0C0C_FF0000FF_11223344_0C0C0C0C);
        chk("cur_vis", visited_color_out,
            128'h0D0D0D0D_FF0000FF_11223344_0D0D0D0D);

        doc_link = 32'hA; doc_visited_link = 32'hB; is_link_element = 1;
        push(2'd2, 1, 0, 10'd102, 32'h0, 1, 1, 0);
        waitIdle("idle_link1");
        chk("link1_reg", color_out,
            128'h0C0C0C0C_0000000A_11223344_0C0C0C0C);
        chk("link1_vis", visited_color_out,
            128'h0D0D0D0D_0000000B_11223344_0D0D0D0D);
        is_link_element = 0;
        push(2'd3, 1, 0, 10'd102, 32'h0, 1, 1, 0);
        waitIdle("idle_link0");
        chk("link0_reg", color_out,
            128'h0000000A_0000000A_11223344_0C0C0C0C);
        chk("link0_vis", visited_color_out,
            128'h0000000A_0000000B_11223344_0D0D0D0D);

        doc_text = 32'h7777; doc_active_link = 32'h8888;
        push(2'd1, 1, 0, 10'd101, 32'h0, 1, 1, 0);
        push(2'd0, 1, 0, 10'd103, 32'h0, 1, 0, 0);
        push(2'd2, 0, 0, 10'd0, 32'hFFFFFFFF, 1, 1, 0);
        waitIdle("idle_text");
        chk("text_act_reg", color_out,
            128'h0000000A_0000000A_00007777_00008888);
        chk("text_act_vis", visited_color_out,
            128'h0000000A_0000000B_00007777_0D0D0D0D);

        push(2'd2, 1, 0, 10'd5, 32'h0, 1, 1, 0);
        step(); step();
        chk("lut_req", 128'(lut_req_valid), 128'(1'b1));
        chk("lut_ident", 128'(lut_ident), 128'(10'd5));
        for (int i = 0; i < 3; i++) begin
            step();
            chk("lut_hold_req", 128'(lut_req_valid), 128'(1'b1));
            chk("lut_hold_id", 128'(lut_ident), 128'(10'd5));
            chk("lut_hold_color", color_out,
                128'h0000000A_0000000A_00007777_00008888);
        end
        lut_color = 32'hCAFEBABE; lut_resp_valid = 1;
        step();
        lut_resp_valid = 0;
        chk("lut_reg", color_out,
            128'h0000000A_CAFEBABE_00007777_00008888);
        chk("lut_vis", visited_color_out,
            128'h0000000A_CAFEBABE_00007777_0D0D0D0D);
        chk("lut_drop", 128'(lut_req_valid), 128'(1'b0));
        chk("lut_busy", 128'(busy), 128'(1'b0));

        lut_color = 32'h12345678; lut_resp_valid = 1;
        step(); step(); step();
        lut_resp_valid = 0;
        chk("stray_reg", color_out,
            128'h0000000A_CAFEBABE_00007777_00008888);
        chk("stray_vis", visited_color_out,
            128'h0000000A_CAFEBABE_00007777_0D0D0D0D);
        chk("stray_busy", 128'(busy), 128'(1'b0));

        accepted = 0;
        push(2'd0, 1, 0, 10'd20, 32'h0, 1, 1, 0);
        waitLut("full_first_lut");
        for (int k = 1; k <= 4; k++)
            push(2'(k % 4), 1, 0, 10'(20 + k), 32'h0, 1, 1, 0);
        chk("full_ready", 128'(req_ready), 128'(1'b0));
        chk("full_accepted", 128'(accepted), 128'(5));
        req_prop = 2'd1; req_ident = 10'd25; req_valid = 1;
        step(); step(); step();
        chk("full_stall_ready", 128'(req_ready), 128'(1'b0));
        chk("full_stall_acc", 128'(accepted), 128'(5));
        for (int k = 0; k < 6; k++) begin
            waitLut("full_wait_lut");
            chk("full_order", 128'(lut_ident), 128'(10'(20 + k)));
            lut_color = 32'hC0DE0000 + 32'(k);
            lut_resp_valid = 1;
            step();
            lut_resp_valid = 0;
            chk("full_drop", 128'(lut_req_valid), 128'(1'b0));
        end
        chk("full_acc_all", 128'(accepted), 128'(6));
        waitIdle("idle_full");
        chk("full_reg", color_out,
            128'hC0DE0003_C0DE0002_C0DE0005_C0DE0004);
        chk("full_vis", visited_color_out,
            128'hC0DE0003_C0DE0002_C0DE0005_C0DE0004);

        push(2'd3, 1, 0, 10'd30, 32'h0, 1, 1, 0);
        waitLut("rstlut_wait");
        chk("rstlut_id", 128'(lut_ident), 128'(10'd30));
        lut_color = 32'hFFFF0000;
        #2 reset = 1'b0;
        #1;
        chk("rstlut_color", color_out, 128'h0);
        chk("rstlut_vis", visited_color_out, 128'h0);
        chk("rstlut_req", 128'(lut_req_valid), 128'(1'b0));
        chk("rstlut_busy", 128'(busy), 128'(1'b0));
        lut_resp_valid = 1;
        step(); step();
        reset = 1'b1;
        step(); step(); step();
        lut_resp_valid = 0;
        chk("post_rst_color", color_out, 128'h0);
        chk("post_rst_vis", visited_color_out, 128'h0);
        chk("post_rst_busy", 128'(busy), 128'(1'b0));
        chk("post_rst_req", 128'(lut_req_valid), 128'(1'b0));
        chk("post_rst_ready", 128'(req_ready), 128'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFail);
        $finish;
    end

endmodule
